// File: rtl/branch_redirect.sv
// Fetch-PC owner: resolves execute-stage control transfers, kills wrong-path IF/ID, vectors on misaligned targets.
// Latency: flush/trap/link combinational in the resolving cycle; if_pc shows the target one edge later.
// Backpressure: stall holds the fetch PC unless a redirect or trap is resolved in the same cycle.
module branch_redirect #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] TRAP_VEC = 32'h0000_0100
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        ex_valid,
  input  logic [1:0]  ex_kind,
  input  logic [31:0] ex_pc,
  input  logic [31:0] ex_imm,
  input  logic [31:0] ex_rs1,
  input  logic        cmp_out,
  output logic [31:0] if_pc,
  output logic        if_valid,
  output logic        flush_if,
  output logic        flush_id,
  output logic [31:0] ex_link,
  output logic        trap,
  output logic [31:0] trap_epc,
  output logic [15:0] redirect_cnt
);

  typedef enum logic [1:0] {ST_BOOT, ST_RUN, ST_TRAP} state_t;

  state_t      r_state, w_state_nxt;
  logic [31:0] r_pc, w_pc_nxt;
  logic        r_vld, w_vld_nxt;
  logic [31:0] r_epc, w_epc_nxt;
  logic [15:0] r_cnt, w_cnt_nxt;

  logic        w_in_run;
  logic        w_take;
  logic [31:0] w_sum;
  logic [31:0] w_target;
  logic        w_misalign;
  logic        w_redirect;

  // Execute-stage inputs only matter while fetching normally; BOOT and TRAP ignore them.
  assign w_in_run   = (r_state == ST_RUN);
  assign w_take     = w_in_run & ex_valid &
                      (((ex_kind == 2'd1) & cmp_out) | (ex_kind == 2'd2) | (ex_kind == 2'd3));
  // jalr adds to rs1 and drops bit 0; branches and jal are PC-relative.
  assign w_sum      = ((ex_kind == 2'd3) ? ex_rs1 : ex_pc) + ex_imm;
  assign w_target   = (ex_kind == 2'd3) ? {w_sum[31:1], 1'b0} : w_sum;
  assign w_misalign = w_take & (w_target[1:0] != 2'b00);
  assign w_redirect = w_take & ~w_misalign;

  // A trap also redirects fetch, so both wrong-path stages are killed on any take.
  assign flush_if = w_take;
  assign flush_id = w_take;
  assign trap     = w_misalign;
  assign ex_link  = ex_pc + 32'd4;

  assign if_pc        = r_pc;
  assign if_valid     = r_vld;
  assign trap_epc     = r_epc;
  assign redirect_cnt = r_cnt;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_BOOT;
    else     r_state <= w_state_nxt;
  end

  // Next state and next fetch PC; trap beats redirect beats stall beats sequential.
  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_vld_nxt   = r_vld;
    w_epc_nxt   = r_epc;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      ST_BOOT: begin
        w_state_nxt = ST_RUN;
        w_vld_nxt   = 1'b1;
      end
      ST_RUN: begin
        if (w_misalign) begin
          w_state_nxt = ST_TRAP;
          w_pc_nxt    = TRAP_VEC;
          w_epc_nxt   = ex_pc;
          w_vld_nxt   = 1'b0;
        end else if (w_redirect) begin
          w_pc_nxt = w_target;
          if (r_cnt != 16'hFFFF) w_cnt_nxt = r_cnt + 16'd1;
        end else if (!stall) begin
          w_pc_nxt = r_pc + 32'd4;
        end
      end
      ST_TRAP: begin
        w_state_nxt = ST_RUN;
        w_vld_nxt   = 1'b1;
      end
      default: begin
        w_state_nxt = ST_BOOT;
        w_vld_nxt   = 1'b0;
      end
    endcase
  end

  // Fetch PC, valid, trap EPC and redirect counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pc  <= RESET_PC;
      r_vld <= 1'b0;
      r_epc <= 32'h0000_0000;
      r_cnt <= 16'h0000;
    end else begin
      r_pc  <= w_pc_nxt;
      r_vld <= w_vld_nxt;
      r_epc <= w_epc_nxt;
      r_cnt <= w_cnt_nxt;
    end
  end

endmodule

// File: tb/tb_branch_redirect.sv
// Bench for branch_redirect: directed scenarios plus random stimulus against a behavioural model.
// Latency: combinational outputs checked mid-cycle, registered outputs checked 1ns after each edge.
// Backpressure: stall is driven randomly and in directed cases.
module tb_branch_redirect;

  localparam longint unsigned M32 = 64'h1_0000_0000;
  localparam int MODE_BOOT = 0;
  localparam int MODE_RUN  = 1;
  localparam int MODE_TRAP = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic        ex_valid;
  logic [1:0]  ex_kind;
  logic [31:0] ex_pc;
  logic [31:0] ex_imm;
  logic [31:0] ex_rs1;
  logic        cmp_out;
  logic [31:0] if_pc;
  logic        if_valid;
  logic        flush_if;
  logic        flush_id;
  logic [31:0] ex_link;
  logic        trap;
  logic [31:0] trap_epc;
  logic [15:0] redirect_cnt;

  int n_chk = 0;
  int n_err = 0;

  // Reference model state.
  int              m_mode;
  longint unsigned m_pc;
  bit              m_vld;
  longint unsigned m_epc;
  int              m_cnt;

  // Combinational outputs observed during the last step.
  logic        o_flush;
  logic        o_trap;
  logic [31:0] o_link;

  always #5 clk = ~clk;

  branch_redirect dut (
    .clk          (clk),
    .rst          (rst),
    .stall        (stall),
    .ex_valid     (ex_valid),
    .ex_kind      (ex_kind),
    .ex_pc        (ex_pc),
    .ex_imm       (ex_imm),
    .ex_rs1       (ex_rs1),
    .cmp_out      (cmp_out),
    .if_pc        (if_pc),
    .if_valid     (if_valid),
    .flush_if     (flush_if),
    .flush_id     (flush_id),
    .ex_link      (ex_link),
    .trap         (trap),
    .trap_epc     (trap_epc),
    .redirect_cnt (redirect_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_mode = MODE_BOOT;
    m_pc   = 0;
    m_vld  = 0;
    m_epc  = 0;
    m_cnt  = 0;
  endtask

  task automatic chk_regs(input string tag);
    chk({tag, ".if_pc"}, if_pc, m_pc[31:0]);
    chk({tag, ".if_valid"}, {31'd0, if_valid}, {31'd0, m_vld});
    chk({tag, ".trap_epc"}, trap_epc, m_epc[31:0]);
    chk({tag, ".cnt"}, {16'd0, redirect_cnt}, m_cnt);
  endtask

  task automatic set_ex(input bit v, input int k, input longint unsigned pc,
                        input longint unsigned imm, input longint unsigned rs1, input bit c);
    ex_valid = v;
    ex_kind  = k[1:0];
    ex_pc    = pc[31:0];
    ex_imm   = imm[31:0];
    ex_rs1   = rs1[31:0];
    cmp_out  = c;
  endtask

  // One clock: called 1ns after a rising edge with inputs already applied.
  task automatic step();
    bit              e_take, e_mis;
    longint unsigned tgt, base, link;
    #1;
    e_take = (m_mode == MODE_RUN) && ex_valid &&
             ((ex_kind == 1 && cmp_out) || ex_kind == 2 || ex_kind == 3);
    base = (ex_kind == 3) ? longint'(ex_rs1) : longint'(ex_pc);
    tgt  = (base + longint'(ex_imm)) % M32;
    if (ex_kind == 3 && (tgt % 2) == 1) tgt = tgt - 1;
    e_mis = e_take && ((tgt % 4) != 0);
    link  = (longint'(ex_pc) + 4) % M32;
    o_flush = flush_if;
    o_trap  = trap;
    o_link  = ex_link;
    chk("flush_if", {31'd0, flush_if}, {31'd0, e_take});
    chk("flush_id", {31'd0, flush_id}, {31'd0, e_take});
    chk("trap", {31'd0, trap}, {31'd0, e_mis});
    chk("ex_link", ex_link, link[31:0]);
    case (m_mode)
      MODE_BOOT: begin m_mode = MODE_RUN; m_vld = 1; end
      MODE_TRAP: begin m_mode = MODE_RUN; m_vld = 1; end
      default: begin
        if (e_mis) begin
          m_mode = MODE_TRAP; m_pc = 32'h100; m_epc = ex_pc; m_vld = 0;
        end else if (e_take) begin
          m_pc  = tgt;
          m_cnt = (m_cnt < 65535) ? m_cnt + 1 : 65535;
        end else if (!stall) begin
          m_pc = (m_pc + 4) % M32;
        end
      end
    endcase
    @(posedge clk);
    #1;
    chk_regs("regs");
  endtask

  initial begin
    rst   = 1'b1;
    stall = 1'b0;
    set_ex(0, 0, 0, 0, 0, 0);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk_regs("reset");
    rst = 1'b0;

    // Boot sequence: one invalid cycle, then 0, 4, 8.
    step(); chk("boot.pc0", if_pc, 32'h0); chk("boot.vld", {31'd0, if_valid}, 32'd1);
    step(); chk("boot.pc4", if_pc, 32'h4);
    step(); chk("boot.pc8", if_pc, 32'h8);

    // Taken branch under stall: redirect wins.
    stall = 1'b1;
    set_ex(1, 1, 32'h40, 32'h20, 0, 1);
    step();
    chk("br.flush", {31'd0, o_flush}, 32'd1);
    chk("br.pc", if_pc, 32'h60);
    chk("br.cnt", {16'd0, redirect_cnt}, 32'd1);
    // Not taken under stall: no flush, PC holds.
    set_ex(1, 1, 32'h40, 32'h20, 0, 0);
    step();
    chk("nt.flush", {31'd0, o_flush}, 32'd0);
    chk("nt.pc", if_pc, 32'h60);
    stall = 1'b0;

    // Misaligned jalr: trap, one bubble with inputs ignored, then TRAP_VEC.
    set_ex(1, 3, 32'h200, 32'h2, 32'h1001, 0);
    step();
    chk("jalr_mis.trap", {31'd0, o_trap}, 32'd1);
    chk("jalr_mis.flush", {31'd0, o_flush}, 32'd1);
    chk("jalr_mis.link", o_link, 32'h204);
    chk("jalr_mis.epc", trap_epc, 32'h200);
    chk("jalr_mis.vld", {31'd0, if_valid}, 32'd0);
    step();
    chk("bubble.trap", {31'd0, o_trap}, 32'd0);
    chk("bubble.vld", {31'd0, if_valid}, 32'd1);
    chk("bubble.pc", if_pc, 32'h100);
    // Aligned jalr with bit 0 cleared.
    set_ex(1, 3, 32'h300, 32'h1, 32'h1003, 0);
    step();
    chk("jalr_ok.pc", if_pc, 32'h1004);
    chk("jalr_ok.link", o_link, 32'h304);
    chk("jalr_ok.trap", {31'd0, o_trap}, 32'd0);

    // Wrap cases.
    set_ex(1, 2, 32'hFFFF_FFF0, 32'hC, 0, 0);
    step(); chk("wrap.pcfffc", if_pc, 32'hFFFF_FFFC);
    set_ex(0, 0, 32'hFFFF_FFFC, 0, 0, 0);
    step(); chk("wrap.seq", if_pc, 32'h0); chk("wrap.link", o_link, 32'h0);
    set_ex(1, 2, 32'hFFFF_FFF0, 32'h10, 0, 0);
    step(); chk("wrap.jal", if_pc, 32'h0);
    // Invalid jal must not redirect.
    set_ex(0, 2, 32'h80, 32'h40, 0, 1);
    step(); chk("inv.flush", {31'd0, o_flush}, 32'd0); chk("inv.pc", if_pc, 32'h4);

    // Random stimulus.
    for (int i = 0; i < 3000; i++) begin
      stall = ($urandom_range(0, 3) == 0);
      set_ex($urandom_range(0, 3) != 0, $urandom_range(0, 3),
             (i % 5 == 0) ? $urandom() : {$urandom_range(0, 65535), 2'b00},
             (i % 7 == 0) ? $urandom() : $urandom_range(0, 255),
             $urandom(), $urandom_range(0, 1));
      step();
    end

    // Counter saturation.
    stall = 1'b0;
    set_ex(1, 2, 32'h1000, 32'h0, 0, 0);
    for (int i = 0; i < 70000; i++) step();
    chk("sat.cnt", {16'd0, redirect_cnt}, 32'h0000_FFFF);

    // Reset during the TRAP bubble, with a taking instruction still presented.
    set_ex(1, 2, 32'h40, 32'h2, 0, 0);
    step();
    chk("pre_rst.epc", trap_epc, 32'h40);
    rst = 1'b1;
    #1;
    model_reset();
    chk_regs("async_rst");
    chk("async_rst.flush", {31'd0, flush_if}, 32'd0);
    chk("async_rst.trap", {31'd0, trap}, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    step();
    chk("rel.flush", {31'd0, o_flush}, 32'd0);
    chk("rel.pc", if_pc, 32'h0);
    chk("rel.vld", {31'd0, if_valid}, 32'd1);
    set_ex(0, 0, 0, 0, 0, 0);
    step(); chk("rel.pc4", if_pc, 32'h4);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
